// File: rtl/ctrl_pipe_if.sv
// Decode-side and observation signals of the control-signal pipeline.
// The master drives decode/hazard inputs; the slave is the pipeline itself.
interface ctrl_pipe_if #(
  parameter int W      = 12,
  parameter int STAGES = 3,
  parameter int CW     = 16
);
  localparam int IW = $clog2(STAGES + 1);

  logic [W-1:0]        sig_in;
  logic                vld_in;
  logic [STAGES-1:0]   stall;
  logic [STAGES-1:0]   flush;
  logic                clr_cnt;

  logic [STAGES*W-1:0] sig_tap;
  logic [STAGES-1:0]   vld_tap;
  logic                dec_hold;
  logic [IW-1:0]       inflight;
  logic [CW-1:0]       stall_cyc;
  logic [CW-1:0]       bubble_cnt;

  modport master (
    output sig_in, vld_in, stall, flush, clr_cnt,
    input  sig_tap, vld_tap, dec_hold, inflight, stall_cyc, bubble_cnt
  );

  modport slave (
    input  sig_in, vld_in, stall, flush, clr_cnt,
    output sig_tap, vld_tap, dec_hold, inflight, stall_cyc, bubble_cnt
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Control bundle pipeline from decode through STAGES registers with per-stage
// stall/flush, bubble insertion, valid tracking and saturating counters.
module ctrl_pipe #(
  parameter int           W      = 12,
  parameter int           STAGES = 3,
  parameter logic [W-1:0] BUBBLE = '0,
  parameter int           CW     = 16
) (
  input logic        clk,
  input logic        rst,
  ctrl_pipe_if.slave bus
);
  localparam int            IW      = $clog2(STAGES + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    UPD_LOAD,
    UPD_HOLD,
    UPD_BUBBLE,
    UPD_FLUSH
  } upd_e;

  logic [W-1:0]      sig_q   [STAGES];
  logic [W-1:0]      sig_d   [STAGES];
  logic [W-1:0]      src_sig [STAGES];
  upd_e              upd     [STAGES];
  logic [STAGES-1:0] vld_q, vld_d, src_vld;
  logic [STAGES-1:0] hold, stall_prev;
  logic [IW-1:0]     inflight_q, inflight_d, n_bubbles;
  logic [CW-1:0]     stall_cyc_q, stall_cyc_d;
  logic [CW-1:0]     bubble_cnt_q, bubble_cnt_d;
  logic [CW:0]       bubble_sum;

  // A stall anywhere downstream freezes every earlier stage as well.
  always_comb begin
    stall_prev = bus.stall << 1;
    src_vld    = STAGES'({vld_q, bus.vld_in});
    src_sig[0] = bus.sig_in;
    for (int k = 1; k < STAGES; k++) src_sig[k] = sig_q[k-1];
    for (int k = 0; k < STAGES; k++) hold[k] = |(bus.stall >> k);
  end

  // Stage 0 sees stall_prev[0]=0, so it is held rather than bubbled.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      if (bus.flush[k])      upd[k] = UPD_FLUSH;
      else if (hold[k])      upd[k] = UPD_HOLD;
      else if (stall_prev[k]) upd[k] = UPD_BUBBLE;
      else                   upd[k] = UPD_LOAD;
    end
  end

  always_comb begin
    n_bubbles  = '0;
    inflight_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      sig_d[k] = sig_q[k];
      vld_d[k] = vld_q[k];
      case (upd[k])
        UPD_FLUSH, UPD_BUBBLE: begin
          sig_d[k] = BUBBLE;
          vld_d[k] = 1'b0;
        end
        UPD_LOAD: begin
          sig_d[k] = src_sig[k];
          vld_d[k] = src_vld[k];
        end
        default: ;
      endcase
      if (upd[k] == UPD_BUBBLE) n_bubbles = n_bubbles + IW'(1);
      inflight_d = inflight_d + IW'(vld_d[k]);
    end
  end

  always_comb begin
    bubble_sum   = {1'b0, bubble_cnt_q} + (CW+1)'(n_bubbles);
    stall_cyc_d  = stall_cyc_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.clr_cnt) begin
      stall_cyc_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if ((|bus.stall) && (stall_cyc_q != CNT_MAX)) stall_cyc_d = stall_cyc_q + CW'(1);
      bubble_cnt_d = bubble_sum[CW] ? CNT_MAX : bubble_sum[CW-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) sig_q[k] <= BUBBLE;
      vld_q        <= '0;
      inflight_q   <= '0;
      stall_cyc_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) sig_q[k] <= sig_d[k];
      vld_q        <= vld_d;
      inflight_q   <= inflight_d;
      stall_cyc_q  <= stall_cyc_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_tap
    assign bus.sig_tap[k*W +: W] = sig_q[k];
  end

  assign bus.vld_tap    = vld_q;
  assign bus.dec_hold   = hold[0];
  assign bus.inflight   = inflight_q;
  assign bus.stall_cyc  = stall_cyc_q;
  assign bus.bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: a reference model queues the expected
// outputs for each cycle, which are popped and compared after the edge.
module tb_ctrl_pipe;
  localparam int           W   = 12;
  localparam int           S   = 3;
  localparam int           CW  = 4;
  localparam int           IW  = $clog2(S + 1);
  localparam logic [W-1:0] BUB = '0;

  typedef struct {
    logic [S*W-1:0] sig;
    logic [S-1:0]   vld;
    logic [IW-1:0]  inf;
    logic [CW-1:0]  sc;
    logic [CW-1:0]  bc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_pipe_if #(.W(W), .STAGES(S), .CW(CW)) bus ();

  ctrl_pipe #(.W(W), .STAGES(S), .BUBBLE(BUB), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];

  logic [W-1:0] m_sig [S];
  logic [S-1:0] m_vld;
  int           m_sc, m_bc;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] tap(input int k);
    return bus.sig_tap[k*W +: W];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < S; k++) m_sig[k] = BUB;
    m_vld = '0;
    m_sc  = 0;
    m_bc  = 0;
  endtask

  task automatic model_step(input logic [W-1:0] s, input logic v, input logic [S-1:0] st,
                            input logic [S-1:0] fl, input logic clr);
    logic [W-1:0] ns [S];
    logic [S-1:0] nv;
    logic [W-1:0] src_s;
    logic         src_v;
    logic         held;
    int           nb;
    int           cnt;
    exp_t         e;
    nb = 0;
    for (int k = 0; k < S; k++) begin
      held = 1'b0;
      for (int j = k; j < S; j++) held = held | st[j];
      if (k == 0) begin
        src_s = s;
        src_v = v;
      end else begin
        src_s = m_sig[k-1];
        src_v = m_vld[k-1];
      end
      if (fl[k]) begin
        ns[k] = BUB; nv[k] = 1'b0;
      end else if (held) begin
        ns[k] = m_sig[k]; nv[k] = m_vld[k];
      end else if (k > 0 && st[k-1]) begin
        ns[k] = BUB; nv[k] = 1'b0; nb++;
      end else begin
        ns[k] = src_s; nv[k] = src_v;
      end
    end
    for (int k = 0; k < S; k++) m_sig[k] = ns[k];
    m_vld = nv;
    if (clr) begin
      m_sc = 0;
      m_bc = 0;
    end else begin
      if (|st) m_sc = (m_sc + 1 > 15) ? 15 : m_sc + 1;
      m_bc = (m_bc + nb > 15) ? 15 : m_bc + nb;
    end
    cnt = 0;
    for (int k = 0; k < S; k++) begin
      e.sig[k*W +: W] = m_sig[k];
      cnt += int'(m_vld[k]);
    end
    e.vld = m_vld;
    e.inf = IW'(cnt);
    e.sc  = CW'(m_sc);
    e.bc  = CW'(m_bc);
    sb.push_back(e);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input logic [W-1:0] s, input logic v, input logic [S-1:0] st,
                       input logic [S-1:0] fl, input logic clr);
    exp_t e;
    bus.sig_in  = s;
    bus.vld_in  = v;
    bus.stall   = st;
    bus.flush   = fl;
    bus.clr_cnt = clr;
    #1;
    check("dec_hold", bus.dec_hold, |st);
    model_step(s, v, st, fl, clr);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("sig_tap", bus.sig_tap, e.sig);
      check("vld_tap", bus.vld_tap, e.vld);
      check("inflight", bus.inflight, e.inf);
      check("stall_cyc", bus.stall_cyc, e.sc);
      check("bubble_cnt", bus.bubble_cnt, e.bc);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.sig_in  = '0;
    bus.vld_in  = 1'b0;
    bus.stall   = '1;
    bus.flush   = '0;
    bus.clr_cnt = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_sig", bus.sig_tap, 36'h0);
    check("rst_vld", bus.vld_tap, 3'b000);
    check("rst_inflight", bus.inflight, 2'd0);
    check("rst_stall_cyc", bus.stall_cyc, 4'd0);
    check("rst_bubble_cnt", bus.bubble_cnt, 4'd0);
    check("rst_dec_hold", bus.dec_hold, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // Free-run
    drive(12'h060, 1, 3'b000, 3'b000, 0);
    check("fr_inflight1", bus.inflight, 2'd1);
    drive(12'h052, 1, 3'b000, 3'b000, 0);
    check("fr_inflight2", bus.inflight, 2'd2);
    drive(12'h016, 1, 3'b000, 3'b000, 0);
    check("fr_inflight3", bus.inflight, 2'd3);
    check("fr_tap2_c3", tap(2), 12'h060);
    drive(12'h000, 0, 3'b000, 3'b000, 0);
    check("fr_tap2_c4", tap(2), 12'h052);
    drive(12'h000, 0, 3'b000, 3'b000, 0);
    check("fr_tap2_c5", tap(2), 12'h016);

    // Single-cycle stall on stage 1 with A in stage 1, B in stage 0
    drive(12'hA01, 1, 3'b000, 3'b000, 1);
    drive(12'hB02, 1, 3'b000, 3'b000, 0);
    drive(12'hC03, 1, 3'b010, 3'b000, 0);
    check("st_tap0", tap(0), 12'hB02);
    check("st_tap1", tap(1), 12'hA01);
    check("st_tap2", tap(2), BUB);
    check("st_vld", bus.vld_tap, 3'b011);
    check("st_bubble_cnt", bus.bubble_cnt, 4'd1);
    check("st_stall_cyc", bus.stall_cyc, 4'd1);
    drive(12'hC03, 1, 3'b000, 3'b000, 0);
    check("st_resume_tap2", tap(2), 12'hA01);

    // Flush during stall on stage 1
    drive(12'hD04, 1, 3'b010, 3'b010, 0);
    check("fs_tap0", tap(0), 12'hC03);
    check("fs_tap1", tap(1), BUB);
    check("fs_vld", bus.vld_tap, 3'b001);
    check("fs_bubble_cnt", bus.bubble_cnt, 4'd2);

    // Multi-stage flush with a full pipe
    drive(12'hD04, 1, 3'b000, 3'b000, 0);
    drive(12'hE05, 1, 3'b000, 3'b000, 0);
    check("mf_full", bus.vld_tap, 3'b111);
    drive(12'hF06, 1, 3'b000, 3'b011, 0);
    check("mf_vld", bus.vld_tap, 3'b100);
    check("mf_tap2", tap(2), 12'hD04);
    check("mf_inflight", bus.inflight, 2'd1);

    // Counter saturation
    drive(12'h000, 0, 3'b000, 3'b000, 1);
    for (int i = 0; i < 20; i++) begin
      drive(12'h111, 1, 3'b100, 3'b000, 0);
      if (i == 14) check("sat_sc_15", bus.stall_cyc, 4'd15);
    end
    check("sat_sc_hold", bus.stall_cyc, 4'd15);
    drive(12'h111, 1, 3'b100, 3'b000, 1);
    check("sat_sc_clr", bus.stall_cyc, 4'd0);
    for (int i = 0; i < 18; i++) drive(12'h222, 1, 3'b001, 3'b000, 0);
    check("sat_bc_hold", bus.bubble_cnt, 4'd15);
    drive(12'h222, 1, 3'b001, 3'b000, 1);
    check("sat_bc_clr", bus.bubble_cnt, 4'd0);

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      logic [S-1:0] st, fl;
      st = '0;
      fl = '0;
      for (int k = 0; k < S; k++) begin
        st[k] = ($urandom_range(0, 3) == 0);
        fl[k] = ($urandom_range(0, 9) == 0);
      end
      drive(W'($urandom), 1'($urandom), st, fl, $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset mid-operation
    drive(12'h301, 1, 3'b000, 3'b000, 0);
    drive(12'h302, 1, 3'b000, 3'b000, 0);
    drive(12'h303, 1, 3'b010, 3'b000, 0);
    #2;
    rst = 1'b0;
    #1;
    check("ar_sig", bus.sig_tap, 36'h0);
    check("ar_vld", bus.vld_tap, 3'b000);
    check("ar_inflight", bus.inflight, 2'd0);
    check("ar_stall_cyc", bus.stall_cyc, 4'd0);
    check("ar_bubble_cnt", bus.bubble_cnt, 4'd0);
    model_reset();
    sb.delete();
    bus.sig_in = 12'h5A5;
    bus.vld_in = 1'b1;
    bus.stall  = '0;
    bus.flush  = '0;
    @(posedge clk);
    #1;
    check("ar_held_vld", bus.vld_tap, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    drive(12'h5A5, 1, 3'b000, 3'b000, 0);
    check("ar_first_tap0", tap(0), 12'h5A5);
    check("ar_first_vld", bus.vld_tap, 3'b001);

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
